// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down counter / interval timer.
//   state_t : timer control state (IDLE holds the count, RUN lets it decrement)
//   NIBBLE  : width of one cascadable counter slice
package down_counter_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned NIBBLE = 4;

endpackage

// File: rtl/down_counter_timer_nibble.sv
// One 4-bit slice of the cascadable down counter.
// Ports:
//   CLK     : rising-edge clock
//   RST     : synchronous reset, active-high (Q -> 0)
//   LD_L    : synchronous load, active-low (Q <= LD_DATA)
//   ENT/ENP : count enables; the slice decrements when both are high
//   LD_DATA : load value for this slice
//   Q       : slice count
//   BO      : borrow out, ENT & (Q == 0); drives ENT of the next slice up
module down_counter_timer_nibble
    import down_counter_timer_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD_L,
    input  logic              ENT,
    input  logic              ENP,
    input  logic [NIBBLE-1:0] LD_DATA,
    output logic [NIBBLE-1:0] Q,
    output logic              BO
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= '0;
        end else if (!LD_L) begin
            Q <= LD_DATA;
        end else if (ENT && ENP) begin
            Q <= Q - NIBBLE'(1);
        end
    end

    assign BO = ENT & (Q == '0);

endmodule

// File: rtl/down_counter_timer.sv
// Loadable, cascadable down counter with one-shot / auto-reload timer control.
// Ports:
//   CLK         : rising-edge clock
//   RST         : synchronous reset, active-high
//   LD_L        : synchronous load, active-low; also captures the reload value
//   ENT, ENP    : count enables (ENT also gates BO)
//   AUTO_RELOAD : 1 = reload from RELOAD at terminal count, 0 = stop at zero
//   LD_DATA     : load value
//   Q           : current count
//   BO          : borrow out, ENT & (Q == 0), combinational
//   DONE        : registered one-cycle pulse on the terminal-count edge
//   RUNNING     : registered, high while the timer is in RUN
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD_L,
    input  logic             ENT,
    input  logic             ENP,
    input  logic             AUTO_RELOAD,
    input  logic [WIDTH-1:0] LD_DATA,
    output logic [WIDTH-1:0] Q,
    output logic             BO,
    output logic             DONE,
    output logic             RUNNING
);

    localparam int unsigned NSLICE = WIDTH / NIBBLE;

    state_t           state;
    logic [WIDTH-1:0] reload_q;
    logic             load;
    logic             count_en;
    logic             terminal;
    logic             slice_ld_l;
    logic [WIDTH-1:0] slice_ld_data;
    logic [NSLICE:0]  ent_chain;
    logic             unused_top_bo;

    assign load     = ~LD_L;
    assign count_en = (state == ST_RUN) & ENT & ENP;
    assign terminal = count_en & (Q == WIDTH'(1));

    // The terminal step is performed as a slice load: either the reload
    // value (auto-reload) or zero (one-shot). An external load overrides it.
    assign slice_ld_l    = ~(load | terminal);
    assign slice_ld_data = load        ? LD_DATA  :
                           AUTO_RELOAD ? reload_q : '0;

    // Slice 0 never decrements on the terminal edge (handled by the load
    // path above) nor at zero, so the count cannot wrap to all-ones.
    assign ent_chain[0] = count_en & ~terminal & (Q != '0);

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        down_counter_timer_nibble u_nibble (
            .CLK     (CLK),
            .RST     (RST),
            .LD_L    (slice_ld_l),
            .ENT     (ent_chain[k]),
            .ENP     ((k == 0) ? ENP : 1'b1),
            .LD_DATA (slice_ld_data[k*NIBBLE +: NIBBLE]),
            .Q       (Q[k*NIBBLE +: NIBBLE]),
            .BO      (ent_chain[k+1])
        );
    end

    // Borrow out of the top slice has no consumer inside this block.
    assign unused_top_bo = ent_chain[NSLICE];

    assign BO      = ENT & (Q == '0);
    assign RUNNING = (state == ST_RUN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            reload_q <= '0;
            DONE     <= 1'b0;
        end else if (load) begin
            reload_q <= LD_DATA;
            DONE     <= 1'b0;
            state    <= (LD_DATA != '0) ? ST_RUN : ST_IDLE;
        end else if (terminal) begin
            DONE  <= 1'b1;
            state <= AUTO_RELOAD ? ST_RUN : ST_IDLE;
        end else begin
            DONE <= 1'b0;
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer (WIDTH = 8): a directed
// vector table, a hand-written long countdown, and random stimulus
// compared against a behavioural model.
module tb_down_counter_timer;

    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic         LD_L;
    logic         ENT;
    logic         ENP;
    logic         AUTO_RELOAD;
    logic [W-1:0] LD_DATA;
    logic [W-1:0] Q;
    logic         BO;
    logic         DONE;
    logic         RUNNING;

    int checks   = 0;
    int failures = 0;

    down_counter_timer #(.WIDTH(W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .LD_L        (LD_L),
        .ENT         (ENT),
        .ENP         (ENP),
        .AUTO_RELOAD (AUTO_RELOAD),
        .LD_DATA     (LD_DATA),
        .Q           (Q),
        .BO          (BO),
        .DONE        (DONE),
        .RUNNING     (RUNNING)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic         rst;
        logic         ld_l;
        logic         ent;
        logic         enp;
        logic         auto_r;
        logic [W-1:0] data;
        logic [W-1:0] q;
        logic         done;
        logic         run;
        logic         bo;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state
    int unsigned m_q;
    int unsigned m_rel;
    bit          m_done;
    bit          m_run;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ld_l, input logic ent,
                         input logic enp, input logic auto_r, input logic [W-1:0] data);
        RST = rst; LD_L = ld_l; ENT = ent; ENP = enp; AUTO_RELOAD = auto_r; LD_DATA = data;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic rst, input logic ld_l, input logic ent, input logic enp,
                       input logic auto_r, input logic [W-1:0] data, input logic [W-1:0] q,
                       input logic done, input logic run, input logic bo);
        vec_t v;
        v.rst = rst; v.ld_l = ld_l; v.ent = ent; v.enp = enp; v.auto_r = auto_r;
        v.data = data; v.q = q; v.done = done; v.run = run; v.bo = bo;
        tbl.push_back(v);
    endtask

    // Apply the current inputs to the model for one rising edge.
    task automatic model_edge();
        if (RST) begin
            m_q = 0; m_rel = 0; m_done = 0; m_run = 0;
        end else if (!LD_L) begin
            m_q = LD_DATA; m_rel = LD_DATA; m_done = 0; m_run = (LD_DATA != 0);
        end else if (m_run && ENT && ENP) begin
            if (m_q == 1) begin
                m_done = 1;
                if (AUTO_RELOAD) m_q = m_rel;
                else begin m_q = 0; m_run = 0; end
            end else begin
                m_q = m_q - 1;
                m_done = 0;
            end
        end else begin
            m_done = 0;
        end
    endtask

    initial begin
        int hit;
        drive(1, 1, 1, 1, 0, 8'h00);

        //   rst ld_l ent enp auto data   q     done run bo
        add(1, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        add(1, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        add(1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
        // one-shot from 3
        add(0, 0, 1, 1, 0, 8'h03, 8'h03, 0, 1, 0);
        add(0, 1, 1, 1, 0, 8'h00, 8'h02, 0, 1, 0);
        add(0, 1, 1, 1, 0, 8'h00, 8'h01, 0, 1, 0);
        add(0, 1, 1, 1, 0, 8'h00, 8'h00, 1, 0, 1);
        add(0, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        add(0, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        // auto-reload from 2
        add(0, 0, 1, 1, 1, 8'h02, 8'h02, 0, 1, 0);
        add(0, 1, 1, 1, 1, 8'h00, 8'h01, 0, 1, 0);
        add(0, 1, 1, 1, 1, 8'h00, 8'h02, 1, 1, 0);
        add(0, 1, 1, 1, 1, 8'h00, 8'h01, 0, 1, 0);
        add(0, 1, 1, 1, 1, 8'h00, 8'h02, 1, 1, 0);
        add(0, 1, 1, 1, 1, 8'h00, 8'h01, 0, 1, 0);
        // cross-nibble borrow, then hold with ENP=0
        add(0, 0, 1, 1, 0, 8'h10, 8'h10, 0, 1, 0);
        add(0, 1, 1, 1, 0, 8'h00, 8'h0F, 0, 1, 0);
        add(0, 1, 1, 0, 0, 8'h00, 8'h0F, 0, 1, 0);
        add(0, 1, 1, 0, 0, 8'h00, 8'h0F, 0, 1, 0);
        add(0, 1, 1, 0, 0, 8'h00, 8'h0F, 0, 1, 0);
        // hold with ENT=0
        add(0, 1, 0, 1, 0, 8'h00, 8'h0F, 0, 1, 0);
        // load wins on the terminal edge
        add(0, 0, 1, 1, 0, 8'h01, 8'h01, 0, 1, 0);
        add(0, 0, 1, 1, 0, 8'h05, 8'h05, 0, 1, 0);
        // reset mid-run
        add(0, 0, 1, 1, 0, 8'h7F, 8'h7F, 0, 1, 0);
        add(0, 1, 1, 1, 0, 8'h00, 8'h7E, 0, 1, 0);
        add(1, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        add(0, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        add(0, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        // load zero stays idle; a load of 0xFF runs
        add(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        add(0, 0, 1, 1, 0, 8'hFF, 8'hFF, 0, 1, 0);
        add(0, 1, 1, 1, 0, 8'h00, 8'hFE, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ld_l, tbl[i].ent, tbl[i].enp, tbl[i].auto_r, tbl[i].data);
            step();
            check($sformatf("vec%0d_q", i),    Q,       tbl[i].q);
            check($sformatf("vec%0d_done", i), DONE,    tbl[i].done);
            check($sformatf("vec%0d_run", i),  RUNNING, tbl[i].run);
            check($sformatf("vec%0d_bo", i),   BO,      tbl[i].bo);
        end

        // Long one-shot countdown from 0x20: DONE must arrive on the 32nd count edge.
        drive(0, 0, 1, 1, 0, 8'h20);
        step();
        drive(0, 1, 1, 1, 0, 8'h00);
        hit = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (DONE) begin
                hit = i;
                break;
            end
        end
        check("long_done_edge", hit, 32);
        check("long_q_zero",    Q,   0);
        check("long_idle",      RUNNING, 0);

        // Randomized run against the behavioural model.
        drive(1, 1, 1, 1, 0, 8'h00);
        step();
        m_q = 0; m_rel = 0; m_done = 0; m_run = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 15) != 0),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 7) != 0),
                  W'($urandom_range(0, 1)) != 0,
                  d);
            model_edge();
            step();
            check("rnd_q",    Q,       m_q);
            check("rnd_done", DONE,    m_done);
            check("rnd_run",  RUNNING, m_run);
            check("rnd_bo",   BO,      (ENT && m_q == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
